spec_free_list_ctrl: RTL

Speculative physical-register free list with a flush-recovery sequencer.
- Rename: hands out free pregs through an all-or-nothing, multi-slot ready/valid handshake.
- Commit: returns freed pregs to the list and advances a shadow architectural head.
- Flush: restores the speculative head and count from the architectural copy, then runs a one-cycle recovery state before allocation resumes.

---
 rtl/spec_free_list_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/spec_free_list_ctrl.sv
// Speculative physical-register free list: circular preg array with speculative and
// architectural heads, a shared tail, and a one-cycle flush-recovery sequencer.
module spec_free_list_ctrl #(
   parameter  int PHY_REG_NUM  = 64,
   parameter  int ARCH_REG_NUM = 32,
   parameter  int RENAME_WIDTH = 4,
   parameter  int COMMIT_WIDTH = 4,
   localparam int PW           = $clog2(PHY_REG_NUM),
   localparam int CW           = $clog2(PHY_REG_NUM + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush_i,
   input  logic [RENAME_WIDTH-1:0]      alloc_req_i,
   output logic                         alloc_ready_o,
   output logic [RENAME_WIDTH*PW-1:0]   alloc_preg_o,
   input  logic [COMMIT_WIDTH-1:0]      commit_alloc_i,
   input  logic [COMMIT_WIDTH-1:0]      commit_free_valid_i,
   input  logic [COMMIT_WIDTH*PW-1:0]   commit_free_preg_i,
   output logic [CW-1:0]                free_cnt_o,
   output logic [CW-1:0]                arch_free_cnt_o,
   output logic                         recovering_o
);

   typedef enum logic {NORMAL, RECOVER} state_t;

   state_t        state_q;
   state_t        state_n;

   logic [PW-1:0] fl_mem [PHY_REG_NUM];
   logic [PW-1:0] spec_head;
   logic [PW-1:0] arch_head;
   logic [PW-1:0] tail;
   logic [CW-1:0] spec_cnt;
   logic [CW-1:0] arch_cnt;

   logic [CW-1:0] req_cnt;
   logic [CW-1:0] free_n;
   logic [CW-1:0] commit_n;
   logic [CW-1:0] fire_n;
   logic [CW-1:0] spec_cnt_n;
   logic [CW-1:0] arch_cnt_n;
   logic [PW-1:0] arch_head_n;
   logic [PW-1:0] free_idx [COMMIT_WIDTH];

   // Slot k reads the entry offset by the number of requesting slots below it.
   always_comb begin
      req_cnt      = '0;
      alloc_preg_o = '0;
      for (int k = 0; k < RENAME_WIDTH; k++) begin
         alloc_preg_o[k*PW +: PW] = fl_mem[spec_head + req_cnt[PW-1:0]];
         req_cnt = req_cnt + CW'(alloc_req_i[k]);
      end
   end

   always_comb begin
      free_n   = '0;
      commit_n = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         free_idx[k] = tail + free_n[PW-1:0];
         free_n      = free_n + CW'(commit_free_valid_i[k]);
         commit_n    = commit_n + CW'(commit_alloc_i[k]);
      end
   end

   assign alloc_ready_o = (state_q == NORMAL) && !flush_i && (spec_cnt >= req_cnt);
   assign fire_n        = (alloc_ready_o && (req_cnt != '0)) ? req_cnt : '0;
   assign spec_cnt_n    = spec_cnt - fire_n + free_n;
   assign arch_cnt_n    = arch_cnt - commit_n + free_n;
   assign arch_head_n   = arch_head + commit_n[PW-1:0];

   // Frees land in every state; reset reloads the pregs not mapped architecturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PHY_REG_NUM; i++) begin
            fl_mem[i] <= (i < PHY_REG_NUM - ARCH_REG_NUM) ? PW'(ARCH_REG_NUM + i) : '0;
         end
      end else begin
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_free_valid_i[k]) begin
               fl_mem[free_idx[k]] <= commit_free_preg_i[k*PW +: PW];
            end
         end
      end
   end

   // A flush copies the post-commit architectural view into the speculative one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spec_head <= '0;
         arch_head <= '0;
         tail      <= PW'(PHY_REG_NUM - ARCH_REG_NUM);
         spec_cnt  <= CW'(PHY_REG_NUM - ARCH_REG_NUM);
         arch_cnt  <= CW'(PHY_REG_NUM - ARCH_REG_NUM);
      end else begin
         tail      <= tail + free_n[PW-1:0];
         arch_head <= arch_head_n;
         arch_cnt  <= arch_cnt_n;
         if (flush_i) begin
            spec_head <= arch_head_n;
            spec_cnt  <= arch_cnt_n;
         end else begin
            spec_head <= spec_head + fire_n[PW-1:0];
            spec_cnt  <= spec_cnt_n;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= NORMAL;
      end else begin
         state_q <= state_n;
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         NORMAL:  if (flush_i)  state_n = RECOVER;
         RECOVER: if (!flush_i) state_n = NORMAL;
         default: state_n = NORMAL;
      endcase
   end

   assign recovering_o    = (state_q == RECOVER);
   assign free_cnt_o      = spec_cnt;
   assign arch_free_cnt_o = arch_cnt;

   a_spec_cap: assert property (@(posedge clk) disable iff (!rst_n)
      spec_cnt_n <= CW'(PHY_REG_NUM));
   a_arch_cap: assert property (@(posedge clk) disable iff (!rst_n)
      arch_cnt_n <= CW'(PHY_REG_NUM));
   a_commit_bound: assert property (@(posedge clk) disable iff (!rst_n)
      commit_n <= (arch_cnt - spec_cnt));
   a_cnt_order: assert property (@(posedge clk) disable iff (!rst_n)
      spec_cnt <= arch_cnt);

endmodule
